// File: rtl/mem_access.sv
// Memory-access pipeline stage: forwards EX ops to WB and performs at most one
// data-bus load/store per op, with misalignment checks and flush/discard handling.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  ex_lsu_op,
  input  logic        ex_mem_en,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_st_data,
  input  logic        ex_rw_en,
  input  logic [4:0]  ex_rw_addr,
  input  logic [31:0] ex_rw_data,
  input  logic [15:0] ex_except_type,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [3:0]  wb_lsu_op,
  output logic        wb_rw_en,
  output logic [4:0]  wb_rw_addr,
  output logic [31:0] wb_rw_data,
  output logic        wb_ram_rd_en,
  output logic [31:0] wb_ram_rd_data,
  output logic [15:0] wb_except_type,
  output logic [31:0] wb_badv,
  input  logic        flush
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [15:0] EXC_ALE = 16'h0200;

  state_t      state_q, state_d;
  logic        discard_q, discard_d;
  logic        accept, capture;
  logic        is_store, is_load, op_half, op_word, exc_in, ale, go_bus;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;

  // Bit 2 of the op code marks stores; bits [1:0] give the access size.
  assign is_store = ex_mem_en && ex_lsu_op[2];
  assign is_load  = ex_mem_en && !ex_lsu_op[2];
  assign op_half  = (ex_lsu_op[1:0] == 2'b01);
  assign op_word  = ex_lsu_op[1];
  assign exc_in   = |ex_except_type;
  assign ale      = ex_mem_en && !exc_in &&
                    ((op_half && ex_addr[0]) || (op_word && (|ex_addr[1:0])));
  assign go_bus   = ex_mem_en && !exc_in && !ale;

  assign ex_ready = (state_q == S_IDLE);
  assign accept   = ex_valid && ex_ready && !flush;

  always_comb begin
    st_wstrb = '0;
    st_wdata = ex_st_data;
    if (is_store) begin
      if (op_word) begin
        st_wstrb = '1;
      end else if (op_half) begin
        st_wstrb = 4'b0011 << ex_addr[1:0];
        st_wdata = {2{ex_st_data[15:0]}};
      end else begin
        st_wstrb = 4'b0001 << ex_addr[1:0];
        st_wdata = {4{ex_st_data[7:0]}};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    data_req  = 1'b0;
    wb_valid  = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = go_bus ? S_REQ : S_DONE;
      S_REQ: begin
        // A flush withdraws the request unless the bus takes it this same cycle.
        data_req = !flush || data_addr_ok;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_d = flush ? S_IDLE : S_DONE;
            capture = !flush;
          end else begin
            state_d   = S_WAIT;
            discard_d = flush;
          end
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_d   = (discard_q || flush) ? S_IDLE : S_DONE;
          capture   = !(discard_q || flush);
          discard_d = 1'b0;
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      S_DONE: begin
        wb_valid = !flush;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      discard_q      <= 1'b0;
      data_wr        <= 1'b0;
      data_wstrb     <= '0;
      data_addr      <= '0;
      data_wdata     <= '0;
      wb_pc          <= '0;
      wb_lsu_op      <= '0;
      wb_rw_en       <= 1'b0;
      wb_rw_addr     <= '0;
      wb_rw_data     <= '0;
      wb_ram_rd_en   <= 1'b0;
      wb_ram_rd_data <= '0;
      wb_except_type <= '0;
      wb_badv        <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (accept) begin
        wb_pc          <= ex_pc;
        wb_lsu_op      <= ex_lsu_op;
        wb_rw_addr     <= ex_rw_addr;
        wb_rw_en       <= ex_rw_en && !is_store && !exc_in && !ale;
        wb_rw_data     <= is_load ? ex_addr : ex_rw_data;
        wb_ram_rd_en   <= is_load;
        wb_except_type <= exc_in ? ex_except_type : (ale ? EXC_ALE : '0);
        wb_badv        <= ale ? ex_addr : '0;
        data_addr      <= {ex_addr[31:2], 2'b00};
        data_wr        <= is_store;
        data_wstrb     <= st_wstrb;
        data_wdata     <= st_wdata;
      end
      if (capture) wb_ram_rd_data <= data_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: reference model predicts WB results, bus
// requests and ready timing; a scripted bus responder drives addr_ok/data_ok.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic [31:0] ex_pc = '0;
  logic [3:0]  ex_lsu_op = '0;
  logic        ex_mem_en = 1'b0;
  logic [31:0] ex_addr = '0, ex_st_data = '0;
  logic        ex_rw_en = 1'b0;
  logic [4:0]  ex_rw_addr = '0;
  logic [31:0] ex_rw_data = '0;
  logic [15:0] ex_except_type = '0;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_valid, wb_rw_en, wb_ram_rd_en;
  logic [31:0] wb_pc, wb_rw_data, wb_ram_rd_data, wb_badv;
  logic [3:0]  wb_lsu_op;
  logic [4:0]  wb_rw_addr;
  logic [15:0] wb_except_type;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_lsu_op(ex_lsu_op),
    .ex_mem_en(ex_mem_en), .ex_addr(ex_addr), .ex_st_data(ex_st_data), .ex_rw_en(ex_rw_en),
    .ex_rw_addr(ex_rw_addr), .ex_rw_data(ex_rw_data), .ex_except_type(ex_except_type),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_lsu_op(wb_lsu_op), .wb_rw_en(wb_rw_en),
    .wb_rw_addr(wb_rw_addr), .wb_rw_data(wb_rw_data), .wb_ram_rd_en(wb_ram_rd_en),
    .wb_ram_rd_data(wb_ram_rd_data), .wb_except_type(wb_except_type), .wb_badv(wb_badv),
    .flush(flush)
  );

  typedef struct {
    logic [31:0] pc; logic [3:0] op; logic rw_en; logic [4:0] rw_addr; logic [31:0] rw_data;
    logic rd_en; logic chk_rd; logic [31:0] rd_data; logic [15:0] exc; logic chk_badv;
    logic [31:0] badv; int unsigned lat; int unsigned acc_cyc;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr; logic wr; logic [3:0] wstrb; logic [31:0] wdata; logic [31:0] rdata;
    int unsigned aok; int unsigned dok;
  } bus_exp_t;

  wb_exp_t     wq[$];
  bus_exp_t    bq[$];
  int          errors = 0, checks = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned op_bytes(input logic [3:0] op);
    case (op)
      4'b0000, 4'b1000, 4'b0100: return 1;
      4'b0001, 4'b1001, 4'b0101: return 2;
      default:                   return 4;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return op inside {4'b0110, 4'b0100, 4'b0101};
  endfunction

  function automatic bus_exp_t make_bus(input logic [3:0] op, input logic [31:0] addr,
                                        input logic [31:0] st, input logic [31:0] rdata,
                                        input int unsigned aok, input int unsigned dok);
    bus_exp_t    be;
    int unsigned bytes, off;
    bytes    = op_bytes(op);
    off      = int'(addr % 4);
    be.addr  = addr - (addr % 4);
    be.wr    = op_store(op);
    be.wstrb = '0;
    be.wdata = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be.wr && b >= off && b < off + bytes) be.wstrb[b] = 1'b1;
      be.wdata[8*b +: 8] = st[8*(b % bytes) +: 8];
    end
    be.rdata = rdata;
    be.aok   = aok;
    be.dok   = dok;
    return be;
  endfunction

  // Bus responder and request checker.
  int unsigned req_cnt = 0, dok_cnt = 0;
  bit          outst = 0;
  bus_exp_t    cur;
  initial begin
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
      end else begin
        data_addr_ok = !outst && bq.size() > 0 && !ex_ready && req_cnt >= bq[0].aok;
        data_data_ok = outst ? (dok_cnt + 1 >= cur.dok) : (data_addr_ok && bq[0].dok == 0);
        data_rdata   = data_data_ok ? (outst ? cur.rdata : bq[0].rdata) : $urandom;
      end
      #2;
      if (rst) begin
        outst = 0; req_cnt = 0; bq.delete();
      end else if (data_req) begin
        check("bus_outstanding", 32'(outst), 0);
        check("ex_ready_during_req", 32'(ex_ready), 0);
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected_req: data_req=1, required 0 (t=%0t)", $time);
        end else begin
          check("data_addr", data_addr, bq[0].addr);
          check("data_wr", 32'(data_wr), 32'(bq[0].wr));
          check("data_wstrb", 32'(data_wstrb), 32'(bq[0].wstrb));
          if (bq[0].wr) check("data_wdata", data_wdata, bq[0].wdata);
          if (data_addr_ok) begin
            check("req_cycles", req_cnt, bq[0].aok);
            cur = bq.pop_front();
            req_cnt = 0;
            if (!data_data_ok) begin outst = 1; dok_cnt = 0; end
          end else begin
            req_cnt++;
          end
        end
      end else if (outst) begin
        if (data_data_ok) outst = 0; else dok_cnt++;
      end else begin
        req_cnt = 0;
      end
    end
  end

  // WB monitor.
  initial begin : wb_mon
    wb_exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && wb_valid === 1'b1) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: wb_valid=1, required 0 (t=%0t)", $time);
        end else begin
          e = wq.pop_front();
          check("wb_latency", cyc - e.acc_cyc, e.lat - 1);
          check("wb_pc", wb_pc, e.pc);
          check("wb_lsu_op", 32'(wb_lsu_op), 32'(e.op));
          check("wb_rw_en", 32'(wb_rw_en), 32'(e.rw_en));
          check("wb_rw_addr", 32'(wb_rw_addr), 32'(e.rw_addr));
          check("wb_rw_data", wb_rw_data, e.rw_data);
          check("wb_ram_rd_en", 32'(wb_ram_rd_en), 32'(e.rd_en));
          check("wb_except_type", 32'(wb_except_type), 32'(e.exc));
          if (e.chk_rd) check("wb_ram_rd_data", wb_ram_rd_data, e.rd_data);
          if (e.chk_badv) check("wb_badv", wb_badv, e.badv);
        end
      end
    end
  end

  // Issue one op at +1 of a cycle where ex_ready is high; returns at +1 of the
  // first cycle ex_ready is high again. flush_sel 0 = no flush, else flush on
  // cycle 1 + (flush_sel-1) % L after accept, L being the op's WB latency.
  task automatic run_op(input logic [3:0] op, input logic mem_en, input logic [31:0] addr,
                        input logic [31:0] st, input logic rw_en, input logic [4:0] rwa,
                        input logic [31:0] rwd, input logic [15:0] exc, input logic [31:0] rdata,
                        input int unsigned aok, input int unsigned dok,
                        input int unsigned flush_sel);
    int unsigned bytes, lat, fj, rdy, k;
    bit          store, load, ale, bus;
    wb_exp_t     w;
    bytes = op_bytes(op);
    store = mem_en && op_store(op);
    load  = mem_en && !op_store(op);
    ale   = mem_en && exc == 0 && (addr % bytes != 0);
    bus   = mem_en && exc == 0 && !ale;
    lat   = bus ? 2 + aok + dok : 1;
    fj    = (flush_sel == 0) ? 0 : 1 + (flush_sel - 1) % lat;
    if (fj == 0)                                  rdy = lat + 1;
    else if (bus && fj <= 1 + aok)                rdy = (fj == 1 + aok && dok > 0) ? lat : fj + 1;
    else if (fj < lat)                            rdy = lat;
    else                                          rdy = fj + 1;

    ex_valid = 1'b1; ex_lsu_op = op; ex_mem_en = mem_en; ex_addr = addr; ex_st_data = st;
    ex_rw_en = rw_en; ex_rw_addr = rwa; ex_rw_data = rwd; ex_except_type = exc;
    ex_pc = $urandom; flush = 1'b0;
    w.pc = ex_pc;
    bq.delete();
    if (bus) bq.push_back(make_bus(op, addr, st, rdata, aok, dok));
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_pc = $urandom; ex_addr = $urandom; ex_rw_data = $urandom;
    ex_lsu_op = 4'($urandom); ex_except_type = 16'($urandom); ex_rw_en = 1'($urandom);

    w.op = op; w.rw_en = rw_en && !store && exc == 0 && !ale; w.rw_addr = rwa;
    w.rw_data = load ? addr : rwd; w.rd_en = load; w.chk_rd = load && bus; w.rd_data = rdata;
    w.exc = (exc != 0) ? exc : (ale ? 16'h0200 : 16'h0000);
    w.chk_badv = ale; w.badv = addr; w.lat = lat; w.acc_cyc = cyc;
    if (fj == 0) wq.push_back(w);

    k = 1;
    while (k <= 200) begin
      flush = (k == fj);
      if (ex_ready) break;
      @(posedge clk); #1;
      k++;
    end
    flush = 1'b0;
    check("ready_cycle", k, rdy);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ex_ready"}, 32'(ex_ready), 1);
    check({tag, "_data_req"}, 32'(data_req), 0);
    check({tag, "_wb_valid"}, 32'(wb_valid), 0);
    check({tag, "_wb_pc"}, wb_pc, 0);
    check({tag, "_wb_rw_en"}, 32'(wb_rw_en), 0);
    check({tag, "_wb_rw_data"}, wb_rw_data, 0);
    check({tag, "_wb_ram_rd_en"}, 32'(wb_ram_rd_en), 0);
    check({tag, "_wb_ram_rd_data"}, wb_ram_rd_data, 0);
    check({tag, "_wb_except_type"}, 32'(wb_except_type), 0);
    check({tag, "_wb_badv"}, wb_badv, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] ops [8] = '{4'b0010, 4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b0110, 4'b0100, 4'b0101};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Directed cases.
    run_op(4'b0000, 1, 32'h1003, 32'h0, 1, 5'd3, 32'h0, 16'h0, 32'h80FF_0000, 0, 1, 0);
    run_op(4'b0101, 1, 32'h2002, 32'h1234_ABCD, 1, 5'd4, 32'h55, 16'h0, 32'h0, 0, 0, 0);
    run_op(4'b0010, 1, 32'h3001, 32'h0, 1, 5'd5, 32'h0, 16'h0, 32'h0, 0, 0, 0);
    run_op(4'b0010, 1, 32'h4000, 32'h9999_8888, 1, 5'd6, 32'h0, 16'h0, 32'hCAFE_F00D, 4, 1, 0);
    run_op(4'b0010, 1, 32'h5004, 32'h0, 1, 5'd7, 32'h0, 16'h0, 32'h1111_2222, 0, 3, 2);
    run_op(4'b0010, 0, 32'h0, 32'h0, 1, 5'd8, 32'hABCD, 16'h0020, 32'h0, 0, 0, 0);

    // Flush on the accepting cycle drops the op.
    ex_valid = 1'b1; ex_lsu_op = 4'b0110; ex_mem_en = 1'b1; ex_addr = 32'h7000; ex_except_type = '0;
    flush = 1'b1;
    bq.delete();
    @(posedge clk); #1;
    ex_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ready", 32'(ex_ready), 1);
    repeat (3) @(posedge clk);
    #1;

    // Randomised ops.
    for (int unsigned n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [15:0] exc;
      op  = ops[$urandom % 8];
      exc = ($urandom % 8 == 0) ? (16'(1) << ($urandom % 16)) : 16'h0;
      run_op(op, ($urandom % 4) != 0, $urandom, $urandom, 1'($urandom), 5'($urandom),
             $urandom, exc, $urandom, $urandom % 4, $urandom % 4,
             ($urandom % 6 == 0) ? 1 + $urandom % 8 : 0);
      if ($urandom % 3 == 0) begin @(posedge clk); #1; end
    end

    // Reset while the op waits for its response.
    ex_valid = 1'b1; ex_lsu_op = 4'b0010; ex_mem_en = 1'b1; ex_addr = 32'h6000;
    ex_except_type = '0; ex_rw_en = 1'b1;
    bq.delete();
    bq.push_back(make_bus(4'b0010, 32'h6000, 32'h0, 32'h0, 1, 6));
    @(posedge clk); #1;
    ex_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midreset");

    run_op(4'b1001, 1, 32'h8002, 32'h0, 1, 5'd9, 32'h0, 16'h0, 32'h0BAD_BEEF, 1, 2, 0);
    repeat (5) @(posedge clk);
    #1;
    check("wb_queue_drained", wq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
